// File: rtl/est_ls_avg_if.sv
// Pilot inputs and published estimate outputs of the least-squares estimator.
// The demapper/equaliser side is the master; the estimator is the slave.
interface est_ls_avg_if #(
  parameter int DATA_WIDTH = 16,
  parameter int N_SC       = 12
) ();
  logic [2:0]                        i_symbol_num;
  logic                              i_clear;
  logic [N_SC-1:0][2*DATA_WIDTH-1:0] i_tx_inv_pilot;
  logic [N_SC-1:0][2*DATA_WIDTH-1:0] i_rx_pilot;
  logic [N_SC-1:0][2*DATA_WIDTH-1:0] o_est_ch;
  logic                              o_est_valid;
  logic [N_SC-1:0]                   o_est_done;
  logic                              o_busy;
  logic                              o_overrun;

  modport master (
    output i_symbol_num, i_clear, i_tx_inv_pilot, i_rx_pilot,
    input  o_est_ch, o_est_valid, o_est_done, o_busy, o_overrun
  );

  modport slave (
    input  i_symbol_num, i_clear, i_tx_inv_pilot, i_rx_pilot,
    output o_est_ch, o_est_valid, o_est_done, o_busy, o_overrun
  );
endinterface

// File: rtl/est_ls_avg.sv
// Serial least-squares channel estimator: rx pilot times stored inverse tx pilot per
// subcarrier, averaged over 2^AVG_LOG2 pilot symbols, published with a valid strobe.
//   state    | meaning
//   S_IDLE   | waiting for a rising edge of the pilot symbol index
//   S_MUL    | one subcarrier product per cycle, k = 0..N_SC-1, into the accumulators
//   S_UPDATE | advance round; in the last round publish the averaged estimate
module est_ls_avg #(
  parameter int         DATA_WIDTH = 16,
  parameter int         INT_WIDTH  = 4,
  parameter int         FRAC_WIDTH = 12,
  parameter int         N_SC       = 12,
  parameter int         AVG_LOG2   = 1,
  parameter logic [2:0] PILOT_SYM  = 3'd4
) (
  input logic         i_clk_est,
  input logic         i_rst_n,
  est_ls_avg_if.slave bus
);
  localparam int PW       = 2*DATA_WIDTH + 1;
  localparam int AW       = DATA_WIDTH + AVG_LOG2;
  localparam int KW       = (N_SC > 1) ? $clog2(N_SC) : 1;
  localparam int RW       = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int N_ROUNDS = 1 << AVG_LOG2;
  localparam int AVG_SH   = (AVG_LOG2 > 0) ? AVG_LOG2 - 1 : 0;

  localparam logic signed [PW-1:0] PROD_RND = PW'(1) << (FRAC_WIDTH - 1);
  localparam logic signed [PW-1:0] SAT_MAX  = PW'((2**(DATA_WIDTH-1)) - 1);
  localparam logic signed [PW-1:0] SAT_MIN  = ~SAT_MAX;
  localparam logic signed [AW:0]   AVG_RND  = (AW+1)'((AVG_LOG2 > 0) ? (1 << AVG_SH) : 0);

  if (INT_WIDTH + FRAC_WIDTH != DATA_WIDTH) begin : g_bad_format
    $error("est_ls_avg: INT_WIDTH + FRAC_WIDTH must equal DATA_WIDTH");
  end
  if (N_SC < 1 || N_SC > 16 || AVG_LOG2 < 0 || AVG_LOG2 > 3) begin : g_bad_size
    $error("est_ls_avg: N_SC must be 1..16 and AVG_LOG2 0..3");
  end

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_UPDATE} state_t;

  state_t                            state;
  logic [KW-1:0]                     k;
  logic [RW-1:0]                     round;
  logic [2:0]                        sym_prev;
  logic signed [AW-1:0]              acc_re [N_SC];
  logic signed [AW-1:0]              acc_im [N_SC];
  logic [N_SC-1:0][2*DATA_WIDTH-1:0] est_ch;
  logic                              est_valid;
  logic [N_SC-1:0]                   est_done;
  logic                              busy;
  logic                              overrun;

  logic                          trigger;
  logic                          last_round;
  logic                          last_k;
  logic signed [DATA_WIDTH-1:0]  ar, ai, br, bi;
  logic signed [PW-1:0]          prod_re, prod_im;
  logic signed [DATA_WIDTH-1:0]  p_re, p_im;
  logic signed [AW-1:0]          p_re_x, p_im_x;

  // Round half up, then clamp into the component range.
  function automatic logic [DATA_WIDTH-1:0] round_sat(input logic signed [PW-1:0] x);
    logic signed [PW-1:0] r;
    r = (x + PROD_RND) >>> FRAC_WIDTH;
    if (r > SAT_MAX)      return SAT_MAX[DATA_WIDTH-1:0];
    else if (r < SAT_MIN) return SAT_MIN[DATA_WIDTH-1:0];
    else                  return r[DATA_WIDTH-1:0];
  endfunction

  // The sum of 2^AVG_LOG2 saturated products always fits back into DATA_WIDTH after the divide.
  function automatic logic [DATA_WIDTH-1:0] avg_round(input logic signed [AW-1:0] a);
    logic signed [AW:0] t;
    t = (AW+1)'(a) + AVG_RND;
    t = t >>> AVG_LOG2;
    return t[DATA_WIDTH-1:0];
  endfunction

  assign trigger    = (bus.i_symbol_num == PILOT_SYM) && (sym_prev != PILOT_SYM);
  assign last_round = (round == RW'(N_ROUNDS - 1));
  assign last_k     = (k == KW'(N_SC - 1));

  assign {ar, ai} = bus.i_tx_inv_pilot[k];
  assign {br, bi} = bus.i_rx_pilot[k];
  assign prod_re  = PW'(ar) * PW'(br) - PW'(ai) * PW'(bi);
  assign prod_im  = PW'(ar) * PW'(bi) + PW'(ai) * PW'(br);
  assign p_re     = round_sat(prod_re);
  assign p_im     = round_sat(prod_im);
  assign p_re_x   = AW'(p_re);
  assign p_im_x   = AW'(p_im);

  always_ff @(posedge i_clk_est or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= S_IDLE;
      k         <= '0;
      round     <= '0;
      sym_prev  <= '0;
      est_ch    <= '0;
      est_valid <= 1'b0;
      est_done  <= '0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
      for (int j = 0; j < N_SC; j++) begin
        acc_re[j] <= '0;
        acc_im[j] <= '0;
      end
    end else begin
      sym_prev  <= bus.i_symbol_num;
      est_valid <= 1'b0;
      if (bus.i_clear) begin
        // Clear beats a coincident trigger; the published estimate is left alone.
        state    <= S_IDLE;
        k        <= '0;
        round    <= '0;
        est_done <= '0;
        busy     <= 1'b0;
        overrun  <= 1'b0;
        for (int j = 0; j < N_SC; j++) begin
          acc_re[j] <= '0;
          acc_im[j] <= '0;
        end
      end else begin
        if (trigger && state != S_IDLE) overrun <= 1'b1;
        case (state)
          S_IDLE: begin
            if (trigger) begin
              state <= S_MUL;
              k     <= '0;
              busy  <= 1'b1;
              if (round == '0) est_done <= '0;
            end
          end
          S_MUL: begin
            acc_re[k] <= (round == '0) ? p_re_x : acc_re[k] + p_re_x;
            acc_im[k] <= (round == '0) ? p_im_x : acc_im[k] + p_im_x;
            if (last_round) est_done[k] <= 1'b1;
            if (last_k) state <= S_UPDATE;
            else        k     <= k + 1'b1;
          end
          S_UPDATE: begin
            if (last_round) begin
              for (int j = 0; j < N_SC; j++)
                est_ch[j] <= {avg_round(acc_re[j]), avg_round(acc_im[j])};
              est_valid <= 1'b1;
              round     <= '0;
            end else begin
              round <= round + 1'b1;
            end
            state <= S_IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.o_est_ch    = est_ch;
  assign bus.o_est_valid = est_valid;
  assign bus.o_est_done  = est_done;
  assign bus.o_busy      = busy;
  assign bus.o_overrun   = overrun;
endmodule

// File: tb/tb_est_ls_avg.sv
// Directed bench for est_ls_avg: single-shot instance (AVG_LOG2=0) and a two-symbol
// averaging instance (AVG_LOG2=1) sharing one stimulus.
module tb_est_ls_avg;
  localparam int DW  = 16;
  localparam int NSC = 12;

  typedef struct {
    logic [15:0] tx_re, tx_im, rx_re, rx_im, step, exp_re, exp_im;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  est_ls_avg_if #(.DATA_WIDTH(DW), .N_SC(NSC)) if0 ();
  est_ls_avg_if #(.DATA_WIDTH(DW), .N_SC(NSC)) if1 ();

  assign if1.i_symbol_num   = if0.i_symbol_num;
  assign if1.i_clear        = if0.i_clear;
  assign if1.i_tx_inv_pilot = if0.i_tx_inv_pilot;
  assign if1.i_rx_pilot     = if0.i_rx_pilot;

  est_ls_avg #(.DATA_WIDTH(DW), .INT_WIDTH(4), .FRAC_WIDTH(12), .N_SC(NSC),
               .AVG_LOG2(0), .PILOT_SYM(3'd4))
    dut0 (.i_clk_est(clk), .i_rst_n(rst_n), .bus(if0.slave));

  est_ls_avg #(.DATA_WIDTH(DW), .INT_WIDTH(4), .FRAC_WIDTH(12), .N_SC(NSC),
               .AVG_LOG2(1), .PILOT_SYM(3'd4))
    dut1 (.i_clk_est(clk), .i_rst_n(rst_n), .bus(if1.slave));

  int n_checks = 0;
  int n_err    = 0;
  vec_t vecs[7];

  bit             v0_h[17], v1_h[17], b0_h[17];
  logic [NSC-1:0] d0_h[17], d1_h[17];
  int             nv0, nv1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h, want 0x%h", name, act, exp);
    end
  endtask

  task automatic set_all(input vec_t v);
    for (int k = 0; k < NSC; k++) begin
      if0.i_tx_inv_pilot[k] = {v.tx_re, v.tx_im};
      if0.i_rx_pilot[k]     = {16'(v.rx_re + 16'(k) * v.step), v.rx_im};
    end
  endtask

  // Trigger sampled at the first edge (cycle T); history index n is cycle T+n.
  task automatic run_pilot(input bit retrig);
    @(negedge clk);
    if0.i_symbol_num = 3'd4;
    nv0 = 0;
    nv1 = 0;
    for (int n = 1; n <= 16; n++) begin
      @(posedge clk);
      #1;
      v0_h[n] = if0.o_est_valid;
      v1_h[n] = if1.o_est_valid;
      b0_h[n] = if0.o_busy;
      d0_h[n] = if0.o_est_done;
      d1_h[n] = if1.o_est_done;
      nv0 += int'(if0.o_est_valid);
      nv1 += int'(if1.o_est_valid);
      if (n == 1) if0.i_symbol_num = 3'd0;
      if (retrig && n == 3) if0.i_symbol_num = 3'd4;
      if (retrig && n == 4) if0.i_symbol_num = 3'd0;
    end
  endtask

  task automatic check_window(input vec_t v);
    chk("valid_count", nv0, 1);
    chk("valid_at_T14", 32'(v0_h[14]), 1);
    chk("busy_T1", 32'(b0_h[1]), 1);
    chk("busy_T13", 32'(b0_h[13]), 1);
    chk("busy_T14", 32'(b0_h[14]), 0);
    chk("done_T1", d0_h[1], 0);
    chk("done_T7", d0_h[7], 12'h03F);
    chk("done_T14", d0_h[14], 12'hFFF);
    for (int k = 0; k < NSC; k++)
      chk($sformatf("est[%0d]", k), if0.o_est_ch[k],
          {16'(v.exp_re + 16'(k) * v.step), v.exp_im});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int nb, nv;
    vec_t vs;
    //            tx_re     tx_im     rx_re     rx_im     step      exp_re    exp_im
    vecs[0] = '{16'h1000, 16'h0000, 16'h0800, 16'hF800, 16'h0000, 16'h0800, 16'hF800};
    vecs[1] = '{16'h0000, 16'h1000, 16'h0400, 16'h0200, 16'h0000, 16'hFE00, 16'h0400};
    vecs[2] = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h0000, 16'h0000, 16'h7FFF, 16'h7FFF};
    vecs[3] = '{16'h8000, 16'h0000, 16'h7FFF, 16'h0000, 16'h0000, 16'h8000, 16'h0000};
    vecs[4] = '{16'h0800, 16'h0000, 16'h0001, 16'hFFFF, 16'h0000, 16'h0001, 16'h0000};
    vecs[5] = '{16'hF000, 16'h0000, 16'h0123, 16'h0456, 16'h0000, 16'hFEDD, 16'hFBAA};
    vecs[6] = '{16'h1000, 16'h0000, 16'h0010, 16'h0000, 16'h0010, 16'h0010, 16'h0000};

    if0.i_symbol_num   = 3'd0;
    if0.i_clear        = 1'b0;
    if0.i_tx_inv_pilot = '0;
    if0.i_rx_pilot     = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_est", 32'(|if0.o_est_ch), 0);
    chk("rst_valid", 32'(if0.o_est_valid), 0);
    chk("rst_done", if0.o_est_done, 0);
    chk("rst_busy", 32'(if0.o_busy), 0);
    chk("rst_overrun", 32'(if0.o_overrun), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      set_all(vecs[i]);
      run_pilot(1'b0);
      check_window(vecs[i]);
    end
    chk("no_overrun_yet", 32'(if0.o_overrun), 0);

    // Second trigger while multiplying: dropped, flagged, estimate intact.
    set_all(vecs[0]);
    run_pilot(1'b1);
    chk("overrun_set", 32'(if0.o_overrun), 1);
    check_window(vecs[0]);

    // Clear together with a trigger.
    @(negedge clk);
    if0.i_symbol_num = 3'd4;
    if0.i_clear      = 1'b1;
    @(posedge clk);
    #1;
    chk("clr_busy", 32'(if0.o_busy), 0);
    chk("clr_overrun", 32'(if0.o_overrun), 0);
    chk("clr_done", if0.o_est_done, 0);
    chk("clr_est_hold", if0.o_est_ch[0], 32'h0800F800);
    if0.i_clear      = 1'b0;
    if0.i_symbol_num = 3'd0;
    nb = 0;
    nv = 0;
    for (int n = 0; n < 16; n++) begin
      @(posedge clk);
      #1;
      nb += int'(if0.o_busy);
      nv += int'(if0.o_est_valid) + int'(if1.o_est_valid);
    end
    chk("clr_no_busy", nb, 0);
    chk("clr_no_valid", nv, 0);

    // Two-symbol averaging on the AVG_LOG2=1 instance.
    vs = '{16'h1000, 16'h0000, 16'h0100, 16'hFF00, 16'h0000, 16'h0000, 16'h0000};
    set_all(vs);
    run_pilot(1'b0);
    chk("avg_r0_valid", nv1, 0);
    chk("avg_r0_done", d1_h[14], 0);
    vs = '{16'h1000, 16'h0000, 16'h0300, 16'hFF01, 16'h0000, 16'h0000, 16'h0000};
    set_all(vs);
    run_pilot(1'b0);
    chk("avg_r1_valid", nv1, 1);
    chk("avg_r1_valid_T14", 32'(v1_h[14]), 1);
    chk("avg_r1_done_T1", d1_h[1], 0);
    chk("avg_r1_done_T7", d1_h[7], 12'h03F);
    chk("avg_r1_done_T14", d1_h[14], 12'hFFF);
    for (int k = 0; k < NSC; k++)
      chk($sformatf("avg_est[%0d]", k), if1.o_est_ch[k], 32'h0200FF01);

    // Reset asserted during MUL k=5.
    @(negedge clk);
    if0.i_symbol_num = 3'd4;
    for (int n = 1; n <= 6; n++) begin
      @(posedge clk);
      #1;
      if (n == 1) if0.i_symbol_num = 3'd0;
    end
    chk("pre_rst_busy", 32'(if0.o_busy), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_est0", 32'(|if0.o_est_ch), 0);
    chk("mid_rst_est1", 32'(|if1.o_est_ch), 0);
    chk("mid_rst_valid", 32'(if0.o_est_valid), 0);
    chk("mid_rst_done", if0.o_est_done, 0);
    chk("mid_rst_busy", 32'(if0.o_busy), 0);
    chk("mid_rst_overrun", 32'(if0.o_overrun), 0);
    @(negedge clk);
    rst_n = 1'b1;
    nv = 0;
    for (int n = 0; n < 16; n++) begin
      @(posedge clk);
      #1;
      nv += int'(if0.o_est_valid) + int'(if1.o_est_valid);
    end
    chk("post_rst_no_valid", nv, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/est_ls_avg.md
# est_ls_avg

Parametrised least-squares channel estimator for the NB-IoT uplink receiver. It sits between the pilot demapper and the equaliser. It serially multiplies the received DMRS pilot of each of N_SC subcarriers by the stored inverse transmitted pilot, averages the per-subcarrier results over 2^AVG_LOG2 pilot symbols, and publishes a stable estimate vector with a one-cycle valid strobe. It generalises the fixed 12-subcarrier, single-shot estimator with three additions: configurable subcarrier count, time averaging across pilot symbols, and explicit valid/overrun/clear control.

## Interface
- DATA_WIDTH, 16, width of each real/imag component (signed fixed point)
- INT_WIDTH, 4, integer bits of the component format
- FRAC_WIDTH, 12, fraction bits; INT_WIDTH+FRAC_WIDTH == DATA_WIDTH
- N_SC, 12, subcarriers per estimate (1..16)
- AVG_LOG2, 1, log2 of the number of pilot symbols averaged (0..3)
- PILOT_SYM, 4, value of i_symbol_num that marks a pilot symbol
- i_clk_est  in  1  single clock; everything is rising-edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_symbol_num  in  3  current SC-FDMA symbol index (0..6).
- i_clear  in  1  synchronous abort and flush of the averaging window.
- i_tx_inv_pilot  in  [N_SC-1:0] x 2*DATA_WIDTH  inverse pilot per subcarrier as {re,im}.
- i_rx_pilot  in  [N_SC-1:0] x 2*DATA_WIDTH  received pilot per subcarrier as {re,im}.
- o_est_ch  out  [N_SC-1:0] x 2*DATA_WIDTH  published averaged estimate as {re,im}.
- o_est_valid  out  1  one-cycle strobe when o_est_ch updates.
- o_est_done  out  N_SC  per-subcarrier "final-round product accumulated" flags.
- o_busy  out  1  high outside IDLE.
- o_overrun  out  1  sticky flag: a trigger was dropped while busy.

## Operation
- Trigger: i_symbol_num == PILOT_SYM in the current cycle and != PILOT_SYM in the previous registered sample. The registered sample resets to 0.
- FSM states and transitions:
  - IDLE -> MUL on a trigger.
  - MUL runs N_SC cycles with index k = 0..N_SC-1, then -> UPDATE.
  - UPDATE lasts 1 cycle, then -> IDLE.
- In MUL cycle k:
  - Complex product p = tx_inv[k] * rx[k], with re = ar*br - ai*bi and im = ar*bi + ai*br.
  - Each component uses a full 2*DATA_WIDTH+1-bit intermediate.
  - Add 2^(FRAC_WIDTH-1), arithmetic-shift right by FRAC_WIDTH, then saturate to the signed DATA_WIDTH range.
- Accumulators:
  - acc_re[k] and acc_im[k] are DATA_WIDTH+AVG_LOG2 bits signed.
  - In the first round of a window, acc[k] = p. Otherwise acc[k] += p.
- Round counter: 0..2^AVG_LOG2-1, incremented in UPDATE, wraps to 0 after the last round.
- o_est_done:
  - Cleared to 0 when MUL is entered in round 0.
  - Bit k is set at the end of MUL cycle k of the last round.
- UPDATE in the last round:
  - o_est_ch[k] = (acc[k] + 2^(AVG_LOG2-1)) >>> AVG_LOG2 for each component; with AVG_LOG2 = 0 the value is acc unchanged.
  - Pulse o_est_valid.
- UPDATE in a non-last round: o_est_ch holds and there is no strobe.
- Triggers while o_busy is high are ignored and set o_overrun. o_overrun is cleared only by reset or i_clear.
- i_clear:
  - FSM goes to IDLE, the round counter goes to 0, and o_est_done, the accumulators and o_overrun clear.
  - o_est_ch holds its last value.
  - If i_clear coincides with a trigger, the clear wins and the trigger is dropped without setting o_overrun.
- Inputs i_tx_inv_pilot and i_rx_pilot must be stable from the trigger cycle through the last MUL cycle.

## Timing
- Reset state: all outputs 0, FSM in IDLE, round counter 0, accumulators 0.
- Reset mid-operation aborts immediately; no partial publish occurs.
- Timing for a trigger sampled in cycle T:
  - MUL occupies T+1..T+N_SC.
  - UPDATE occurs at T+N_SC+1.
  - o_est_valid and the new o_est_ch are visible from T+N_SC+2.
  - o_busy is high over T+1..T+N_SC+1.
- Published-estimate latency from the first pilot of a window is (2^AVG_LOG2 - 1) pilot periods + N_SC + 2 cycles.
- The earliest back-to-back trigger is accepted at T+N_SC+2.

## Test plan
- Identity pilot: AVG_LOG2=0, every tx_inv = {0x1000,0x0000}, rx[k] = {0x0800,0xF800} -> o_est_ch[k] = {0x0800,0xF800} for all k, valid at T+14 with N_SC=12.
- Complex rotation: tx_inv = {0x0000,0x1000} (j), rx = {0x0400,0x0200} -> est = {0xFE00,0x0400}.
- Saturation: tx_inv = {0x7FFF,0x7FFF}, rx = {0x7FFF,0x0000} -> est = {0x7FFF,0x7FFF}. Negative case: tx_inv = {0x8000,0}, rx = {0x7FFF,0} -> re = 0x8000.
- Averaging: AVG_LOG2=1, first pilot gives products {0x0100,0xFF00} and second gives {0x0300,0xFF01}:
  - No valid after the first pilot.
  - After the second: est = {0x0200,0xFF01}, and o_est_done goes 0 -> all ones only during round 1.
- Overrun, clear and reset:
  - Symbol_num toggles to 4 again during MUL -> o_overrun = 1 and the estimate is unaffected.
  - i_clear at the same cycle as a trigger -> no MUL and o_overrun = 0.
  - i_rst_n low at MUL k=5 -> all outputs 0 and no valid strobe follows.
